byte_serial_tx: RTL
===================

BYTE_SERIAL_TX -- requirements
Module: byte_serial_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clock cycles each serial bit is held; legal range 1..1024.
REQ-002 Parameter PARITY_EN, default 1, 1 = insert even-parity bit after data bits, 0 = omit it.
REQ-003 Parameter MSB_FIRST, default 0, 0 = data bit 0 sent first, 1 = data bit 7 sent first.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_  input  1  reset, synchronous and active-high (rst_=1 resets on the next rising edge of clk).
REQ-006 enable  input  1  load strobe; sampled each edge, accepted only while idle.
REQ-007 data  input  8  byte to transmit, captured on the accepting edge.
REQ-008 tx  output  1  serial line; idle level 1.
REQ-009 busy  output  1  high while a frame is in progress.
REQ-010 done  output  1  one-cycle pulse when a frame completes.
REQ-011 drop  output  1  one-cycle pulse when enable arrives while busy.

Function
REQ-012 States SHALL be IDLE, START, DATA, PARITY, STOP; all outputs SHALL be registered.
REQ-013 IDLE: tx=1, busy=0; enable=1 at an edge SHALL capture data into a shift register and enter START.
REQ-014 Frame order SHALL be START (tx=0), 8 DATA bits, PARITY (only if PARITY_EN=1), STOP (tx=1).
REQ-015 Each bit SHALL be held exactly CLKS_PER_BIT cycles, timed by a baud counter cleared on every bit change.
REQ-016 A 3-bit bit counter SHALL select DATA bits 0..7; DATA exits after the 8th bit completes.
REQ-017 Bit order SHALL follow MSB_FIRST; the captured byte SHALL NOT change mid-frame, whatever data does.
REQ-018 Parity bit SHALL equal XOR of the 8 captured bits (even parity over data+parity).
REQ-019 busy SHALL be 1 from the cycle after acceptance through the last STOP cycle: (10+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-020 On the edge ending STOP, state SHALL go to IDLE, busy to 0, and done to 1 for exactly one cycle.
REQ-021 enable=1 in the done cycle SHALL be accepted, giving back-to-back frames with exactly one idle tx=1 cycle between them.
REQ-022 enable=1 while busy=1 SHALL be ignored for the frame and SHALL pulse drop one cycle later, once per such cycle.
REQ-023 CLKS_PER_BIT=1 SHALL work: one cycle per bit, no extra cycles inserted.
REQ-024 Baud counter width SHALL be max(1, clog2(CLKS_PER_BIT)); no overflow at CLKS_PER_BIT=1024.

Reset
REQ-025 rst_=1 at an edge SHALL force IDLE with tx=1, busy=0, done=0, drop=0, and clear both counters and the shift register.
REQ-026 Reset mid-frame SHALL abort it; tx SHALL be 1 from the next cycle, and no done pulse SHALL occur.
REQ-027 rst_ SHALL dominate enable; enable during reset SHALL NOT be accepted and SHALL NOT cause a drop pulse.

Verification
REQ-028 Defaults, enable with data=8'hA5: tx is 0 (x4), then 1,0,1,0,0,1,0,1 (x4 each), then parity 0 (x4), then stop 1 (x4); busy high 44 cycles; done pulses in cycle 45.
REQ-029 MSB_FIRST=1, PARITY_EN=0, data=8'h80: start 0, data 1,0,0,0,0,0,0,0, stop 1; busy high 40 cycles.
REQ-030 enable pulsed with data=8'h3C at the 10th busy cycle of an 8'hA5 frame: drop pulses once; the frame stays the 8'hA5 waveform; no second frame follows.
REQ-031 enable held high continuously with data=8'h01: consecutive frames with exactly one tx=1 idle cycle between each; done pulses every 45 cycles.
REQ-032 rst_=1 for one cycle during the DATA state: next cycle tx=1, busy=0, no done; a new enable afterwards sends a full correct frame.
REQ-033 CLKS_PER_BIT=1, data=8'hFF, PARITY_EN=1: tx is 0, 1 x8, parity 0, stop 1; busy high 11 cycles.

Source files
------------

// File: rtl/byte_serial_tx.sv
// Byte-wide UART-style serializer: start bit, 8 data bits, optional even parity, stop bit.
// Every output is registered; tx is derived from the state the frame is about to enter.
module byte_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       enable,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       drop
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            drop_q, drop_d;
  logic            baud_end;
  logic [2:0]      sel;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    done_d   = 1'b0;
    drop_d   = enable & busy_q;
    baud_end = (baud_q == BAUD_LAST);
    tx_d     = 1'b1;
    sel      = 3'd0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = START;
          shift_d = data;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (baud_end) state_d = DATA;
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = PARITY_EN ? PARITY : STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (baud_end) state_d = STOP;
      end
      STOP: begin
        if (baud_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Baud counter restarts at every bit boundary so each bit lasts exactly CLKS_PER_BIT cycles.
    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + BW'(1);
    end

    sel = MSB_FIRST ? (3'd7 - bit_d) : bit_d;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[sel];
      PARITY:  tx_d = ^shift_d;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;
  assign drop = drop_q;

endmodule
